// File: rtl/write_buffer_pkg.sv
// Shared constants and drain FSM encoding for the write-through store buffer.
package write_buffer_pkg;

   localparam int unsigned WB_ADDR_W     = 10;
   localparam int unsigned WB_DATA_W     = 32;
   localparam int unsigned WB_BLK_OFF_W  = 4;
   localparam int unsigned WB_WORD_OFF_W = 2;

   typedef enum logic {
      WB_IDLE  = 1'b0,
      WB_DRAIN = 1'b1
   } wb_state_e;

endpackage

// File: rtl/write_buffer_if.sv
// Cache-controller / refill / memory-side signals of the write buffer.
interface write_buffer_if
   import write_buffer_pkg::*;
#(
   parameter int unsigned ADDR_W = WB_ADDR_W,
   parameter int unsigned DATA_W = WB_DATA_W
);

   logic              wb_push;
   logic [ADDR_W-1:0] wb_address;
   logic [DATA_W-1:0] wb_data;
   logic              wb_full;
   logic              wb_empty;

   logic [ADDR_W-1:0] rd_address;
   logic              rd_conflict;
   logic              rd_fwd_valid;
   logic [DATA_W-1:0] rd_fwd_data;

   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;

   modport master (
      output wb_push, wb_address, wb_data, rd_address, mem_ready,
      input  wb_full, wb_empty, rd_conflict, rd_fwd_valid, rd_fwd_data,
             mem_write, mem_address, mem_data
   );

   modport slave (
      input  wb_push, wb_address, wb_data, rd_address, mem_ready,
      output wb_full, wb_empty, rd_conflict, rd_fwd_valid, rd_fwd_data,
             mem_write, mem_address, mem_data
   );

endinterface

// File: rtl/write_buffer.sv
// Circular write-through store buffer draining one entry at a time to memory.
// Define WB_FORWARD_EN to build read-miss data forwarding from buffered stores.
module write_buffer
   import write_buffer_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = WB_ADDR_W,
   parameter int unsigned DATA_W = WB_DATA_W
) (
   input  logic         clk,
   input  logic         reset,
   write_buffer_if.slave bus
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;
   wb_state_e         state;

   logic              full;
   logic              push_ok;
   logic              pop_ok;
   logic [DEPTH-1:0]  valid;
   logic              conflict;

   // Full comes from registered count only, so a same-cycle pop never frees a slot.
   assign full     = (count == CNT_W'(DEPTH));
   assign push_ok  = bus.wb_push && !full;
   assign pop_ok   = (state == WB_DRAIN) && bus.mem_ready;

   assign bus.wb_full     = full;
   assign bus.wb_empty    = (count == '0) && (state == WB_IDLE);
   assign bus.mem_write   = (state == WB_DRAIN);
   assign bus.mem_address = addr_mem[head];
   assign bus.mem_data    = data_mem[head];

   // Pointers, occupancy and drain FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         state <= WB_IDLE;
      end else begin
         if (push_ok) begin
            tail <= tail + PTR_W'(1);
         end
         if (pop_ok) begin
            head <= head + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         case (state)
            WB_IDLE: begin
               if (count != '0) begin
                  state <= WB_DRAIN;
               end
            end
            WB_DRAIN: begin
               if (bus.mem_ready) begin
                  state <= WB_IDLE;
               end
            end
            default: state <= WB_IDLE;
         endcase
      end
   end

   // Entry storage; stale contents are masked by the valid vector.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         addr_mem[tail] <= bus.wb_address;
         data_mem[tail] <= bus.wb_data;
      end
   end

   // An entry is live when its distance from head is below the occupancy.
   always_comb begin
      logic [PTR_W-1:0] age;
      age   = '0;
      valid = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         age      = PTR_W'(i) - head;
         valid[i] = (CNT_W'(age) < count);
      end
   end

   always_comb begin
      conflict = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid[i] &&
             (addr_mem[i][ADDR_W-1:WB_BLK_OFF_W] == bus.rd_address[ADDR_W-1:WB_BLK_OFF_W])) begin
            conflict = 1'b1;
         end
      end
   end

   assign bus.rd_conflict = conflict;

`ifdef WB_FORWARD_EN
   logic              fwd_valid;
   logic [DATA_W-1:0] fwd_data;
   logic              unused_rd_bits;

   // Walk oldest to newest so the entry nearest the tail wins.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx       = '0;
      fwd_valid = 1'b0;
      fwd_data  = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = head + PTR_W'(k);
         if ((CNT_W'(k) < count) &&
             (addr_mem[idx][ADDR_W-1:WB_WORD_OFF_W] ==
              bus.rd_address[ADDR_W-1:WB_WORD_OFF_W])) begin
            fwd_valid = 1'b1;
            fwd_data  = data_mem[idx];
         end
      end
   end

   assign bus.rd_fwd_valid = fwd_valid;
   assign bus.rd_fwd_data  = fwd_data;
   assign unused_rd_bits   = ^bus.rd_address[WB_WORD_OFF_W-1:0];
`else
   logic unused_rd_bits;

   assign bus.rd_fwd_valid = 1'b0;
   assign bus.rd_fwd_data  = '0;
   assign unused_rd_bits   = ^bus.rd_address[WB_BLK_OFF_W-1:0];
`endif

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of 2, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 10, byte address width.
REQ-003 SHALL have parameter DATA_W, default 32, store data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wb_push  input  1  cache controller presents a write-through store this cycle.
REQ-007 wb_address  input  ADDR_W  byte address of pushed store.
REQ-008 wb_data  input  DATA_W  data of pushed store.
REQ-009 wb_full  output  1  no free entry; pushes are ignored while high.
REQ-010 wb_empty  output  1  no valid entry and no drain in progress.
REQ-011 rd_address  input  ADDR_W  address of the cache read miss about to refill.
REQ-012 rd_conflict  output  1  some valid entry lies in the same 16-byte block as rd_address.
REQ-013 rd_fwd_valid  output  1  newest matching word is present (forwarding build only).
REQ-014 rd_fwd_data  output  DATA_W  data of newest entry whose address[ADDR_W-1:2] equals rd_address[ADDR_W-1:2].
REQ-015 mem_write  output  1  write request to main memory.
REQ-016 mem_address  output  ADDR_W  address of head entry.
REQ-017 mem_data  output  DATA_W  data of head entry.
REQ-018 mem_ready  input  1  main memory completed the current write.

Function
REQ-019 Storage SHALL be a circular FIFO of DEPTH entries {address, data} with head pointer, tail pointer and count of width log2(DEPTH)+1.
REQ-020 Push accepted when wb_push=1 and wb_full=0; entry written at tail, tail wraps DEPTH-1 -> 0, count +1, visible to rd_conflict the next cycle.
REQ-021 wb_full SHALL be count==DEPTH from registered state; a pop in the same cycle SHALL NOT admit a push while full.
REQ-022 Drain FSM states: WB_IDLE, WB_DRAIN.
REQ-023 WB_IDLE -> WB_DRAIN when count>0; mem_write=1 only in WB_DRAIN, with mem_address/mem_data from head, held stable until mem_ready.
REQ-024 In WB_DRAIN with mem_ready=1: head advances (wraps), count -1, FSM -> WB_IDLE; next entry issued one cycle later (one idle cycle between writes).
REQ-025 Simultaneous accepted push and pop SHALL leave count unchanged, both pointers advance.
REQ-026 mem_ready while in WB_IDLE SHALL be ignored.
REQ-027 rd_conflict combinational over all valid entries including head being drained; compare bits [ADDR_W-1:4].
REQ-028 Multiple pushes to the same address SHALL be kept as separate entries, drained in order (no coalescing).
REQ-029 wb_empty = (count==0) and FSM in WB_IDLE.

Reset
REQ-030 On reset assertion, immediately: count=0, head=tail=0, FSM=WB_IDLE, mem_write=0, wb_full=0, wb_empty=1, rd_conflict=0, rd_fwd_valid=0, rd_fwd_data=0; entry contents need not be cleared.
REQ-031 Reset during WB_DRAIN SHALL abort the write and discard all entries.

Configuration
REQ-032 Macro WB_FORWARD_EN defined: rd_fwd_valid/rd_fwd_data driven per REQ-014, newest entry (nearest tail) wins among matches.
REQ-033 WB_FORWARD_EN undefined: rd_fwd_valid and rd_fwd_data tied to 0, no match logic synthesised; rd_conflict unaffected.

Structure
REQ-034 Shared package SHALL hold ADDR_W/DATA_W defaults, block-offset width (4), and FSM state encodings WB_IDLE=0, WB_DRAIN=1.
REQ-035 No sub-module; the match/priority logic stays inline.

Verification
REQ-036 Reset, push 0x010/0xAAAA0001 -> next cycle wb_empty=0; mem_write=1, mem_address=0x010; mem_ready at cycle 3 -> wb_empty=1 following cycle.
REQ-037 mem_ready held 0, push 5 stores -> wb_full=1 after 4th, 5th ignored; release mem_ready -> 4 writes in push order.
REQ-038 Full buffer, push and mem_ready same cycle -> push dropped, count 3.
REQ-039 Pushes 0x104/0x11111111 then 0x104/0x22222222, rd_address=0x108 -> rd_conflict=1; rd_address=0x104 with WB_FORWARD_EN -> rd_fwd_valid=1, data 0x22222222; without macro -> 0.
REQ-040 Tail wrap: 10 push/drain cycles with DEPTH=4 -> memory receives all 10 in order, no loss.
REQ-041 Assert reset mid-WB_DRAIN -> mem_write drops in the same cycle, wb_empty=1, no further writes.
